// File: rtl/time_pkg.sv
// time_pkg: shared definitions for the time-setting controller.
//   state_t      : controller states (IDLE, three edit states, COMMIT)
//   MAX_HOUR     : highest legal hour value (23)
//   MAX_MINSEC   : highest legal minute/second value (59)
//   HOUR_W       : width of an hours field
//   MINSEC_W     : width of a minutes/seconds field
//   FSEL_*       : encodings driven on field_sel
package time_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_EDIT_H = 3'd1,
    ST_EDIT_M = 3'd2,
    ST_EDIT_S = 3'd3,
    ST_COMMIT = 3'd4
  } state_t;

  localparam int MAX_HOUR   = 23;
  localparam int MAX_MINSEC = 59;

  localparam int HOUR_W   = 5;
  localparam int MINSEC_W = 6;

  localparam logic [1:0] FSEL_NONE  = 2'd0;
  localparam logic [1:0] FSEL_HOURS = 2'd1;
  localparam logic [1:0] FSEL_MINS  = 2'd2;
  localparam logic [1:0] FSEL_SECS  = 2'd3;

endpackage

// File: rtl/mod_adj.sv
// mod_adj: combinational modulo up/down adjuster for one time field.
//   Parameters: MAX (largest legal value), W (field width)
//   val  in  W : current field value
//   en   in  1 : adjustment allowed this cycle
//   up   in  1 : increment request (MAX wraps to 0)
//   down in  1 : decrement request (0 wraps to MAX)
//   adj  out W : value to hold next; equals val when disabled or when
//                up and down arrive together
module mod_adj
  import time_pkg::*;
#(
  parameter int MAX = MAX_MINSEC,
  parameter int W   = MINSEC_W
) (
  input  logic [W-1:0] val,
  input  logic         en,
  input  logic         up,
  input  logic         down,
  output logic [W-1:0] adj
);

  localparam logic [W-1:0] TOP = W'(MAX);

  always_comb begin
    adj = val;
    if (en && (up != down)) begin
      if (up) begin
        adj = (val == TOP) ? '0 : val + W'(1);
      end else begin
        adj = (val == '0) ? TOP : val - W'(1);
      end
    end
  end

endmodule

// File: rtl/set_ctrl24.sv
// set_ctrl24: button-driven editor for a 24-hour hh:mm:ss time setting.
//   Parameter TIMEOUT_CYCLES : idle cycles in an edit state before auto-abort
//   clk        in  1 : system clock, rising edge
//   rst_n      in  1 : asynchronous active-low reset
//   btn_set    in  1 : pulse, starts an edit from IDLE (captures cur_*)
//   btn_next   in  1 : pulse, advances hours -> mins -> secs -> commit
//   btn_up     in  1 : pulse, increments the selected field
//   btn_down   in  1 : pulse, decrements the selected field
//   btn_cancel in  1 : pulse, abandons the edit without a load
//   cur_hours/cur_mins/cur_secs in 5/6/6 : live time, sampled on entry
//   hours_o/mins_o/secs_o      out 5/6/6 : edited time, registered
//   field_sel  out 2 : 0 none, 1 hours, 2 mins, 3 secs (registered)
//   load       out 1 : one-cycle commit strobe
//   busy       out 1 : high whenever not IDLE
module set_ctrl24
  import time_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                btn_set,
  input  logic                btn_next,
  input  logic                btn_up,
  input  logic                btn_down,
  input  logic                btn_cancel,
  input  logic [HOUR_W-1:0]   cur_hours,
  input  logic [MINSEC_W-1:0] cur_mins,
  input  logic [MINSEC_W-1:0] cur_secs,
  output logic [HOUR_W-1:0]   hours_o,
  output logic [MINSEC_W-1:0] mins_o,
  output logic [MINSEC_W-1:0] secs_o,
  output logic [1:0]          field_sel,
  output logic                load,
  output logic                busy
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t              state;
  state_t              state_nxt;
  logic [CNT_W-1:0]    idle_cnt;
  logic [CNT_W-1:0]    idle_cnt_nxt;
  logic [1:0]          field_sel_nxt;
  logic                load_nxt;
  logic                busy_nxt;
  logic                any_btn;
  logic                in_edit;
  logic                capture;
  logic                adj_ok;
  logic [HOUR_W-1:0]   hours_adj;
  logic [MINSEC_W-1:0] mins_adj;
  logic [MINSEC_W-1:0] secs_adj;

  // Out-of-range captured values are replaced by zero.
  function automatic logic [HOUR_W-1:0] sat_hour(input logic [HOUR_W-1:0] v);
    return (v > HOUR_W'(MAX_HOUR)) ? '0 : v;
  endfunction

  function automatic logic [MINSEC_W-1:0] sat_minsec(input logic [MINSEC_W-1:0] v);
    return (v > MINSEC_W'(MAX_MINSEC)) ? '0 : v;
  endfunction

  // btn_set has no meaning while editing, so it does not count as activity.
  assign any_btn = btn_next | btn_up | btn_down | btn_cancel;
  assign in_edit = (state == ST_EDIT_H) || (state == ST_EDIT_M) || (state == ST_EDIT_S);
  assign capture = (state == ST_IDLE) && btn_set;
  assign adj_ok  = in_edit && !btn_cancel && !btn_next;

  mod_adj #(.MAX(MAX_HOUR), .W(HOUR_W)) u_adj_hours (
    .val  (hours_o),
    .en   (adj_ok && (state == ST_EDIT_H)),
    .up   (btn_up),
    .down (btn_down),
    .adj  (hours_adj)
  );

  mod_adj #(.MAX(MAX_MINSEC), .W(MINSEC_W)) u_adj_mins (
    .val  (mins_o),
    .en   (adj_ok && (state == ST_EDIT_M)),
    .up   (btn_up),
    .down (btn_down),
    .adj  (mins_adj)
  );

  mod_adj #(.MAX(MAX_MINSEC), .W(MINSEC_W)) u_adj_secs (
    .val  (secs_o),
    .en   (adj_ok && (state == ST_EDIT_S)),
    .up   (btn_up),
    .down (btn_down),
    .adj  (secs_adj)
  );

  // Next-state logic: cancel beats next, next beats up/down.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: begin
        if (btn_set) state_nxt = ST_EDIT_H;
      end
      ST_EDIT_H, ST_EDIT_M, ST_EDIT_S: begin
        if (btn_cancel) begin
          state_nxt = ST_IDLE;
        end else if (btn_next) begin
          unique case (state)
            ST_EDIT_H: state_nxt = ST_EDIT_M;
            ST_EDIT_M: state_nxt = ST_EDIT_S;
            default:   state_nxt = ST_COMMIT;
          endcase
        end else if (!any_btn && (idle_cnt == CNT_LAST)) begin
          state_nxt = ST_IDLE;
        end
      end
      ST_COMMIT: state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Counter only advances across quiet cycles spent in the same edit session.
  always_comb begin
    idle_cnt_nxt = '0;
    if (in_edit && !any_btn && (state_nxt != ST_IDLE)) begin
      idle_cnt_nxt = idle_cnt + CNT_W'(1);
    end
  end

  // Outputs are decoded from the next state so they register with it.
  always_comb begin
    field_sel_nxt = FSEL_NONE;
    load_nxt      = 1'b0;
    busy_nxt      = (state_nxt != ST_IDLE);
    unique case (state_nxt)
      ST_EDIT_H: field_sel_nxt = FSEL_HOURS;
      ST_EDIT_M: field_sel_nxt = FSEL_MINS;
      ST_EDIT_S: field_sel_nxt = FSEL_SECS;
      ST_COMMIT: load_nxt      = 1'b1;
      default:   field_sel_nxt = FSEL_NONE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      idle_cnt  <= '0;
      field_sel <= FSEL_NONE;
      load      <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      idle_cnt  <= idle_cnt_nxt;
      field_sel <= field_sel_nxt;
      load      <= load_nxt;
      busy      <= busy_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hours_o <= '0;
      mins_o  <= '0;
      secs_o  <= '0;
    end else if (capture) begin
      hours_o <= sat_hour(cur_hours);
      mins_o  <= sat_minsec(cur_mins);
      secs_o  <= sat_minsec(cur_secs);
    end else begin
      hours_o <= hours_adj;
      mins_o  <= mins_adj;
      secs_o  <= secs_adj;
    end
  end

endmodule

// File: tb/tb_set_ctrl24.sv
module tb_set_ctrl24;

  localparam int TMO = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_set = 1'b0, btn_next = 1'b0, btn_up = 1'b0, btn_down = 1'b0, btn_cancel = 1'b0;
  logic [4:0] cur_hours = '0;
  logic [5:0] cur_mins = '0, cur_secs = '0;
  logic [4:0] hours_o;
  logic [5:0] mins_o, secs_o;
  logic [1:0] field_sel;
  logic       load, busy;

  int checks = 0;
  int failures = 0;

  set_ctrl24 #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .btn_set(btn_set), .btn_next(btn_next), .btn_up(btn_up),
    .btn_down(btn_down), .btn_cancel(btn_cancel),
    .cur_hours(cur_hours), .cur_mins(cur_mins), .cur_secs(cur_secs),
    .hours_o(hours_o), .mins_o(mins_o), .secs_o(secs_o),
    .field_sel(field_sel), .load(load), .busy(busy)
  );

  always #5 clk = ~clk;

  // {hours, mins, secs, field_sel, load, busy}
  logic [20:0] dut_pack;
  assign dut_pack = {hours_o, mins_o, secs_o, field_sel, load, busy};

  typedef struct {
    logic set, nxt, up, dn, cxl;
    int ch, cm, cs;
    int eh, em, es, ef;
    logic el, eb;
  } vec_t;

  vec_t tbl[$];

  // Reference model: the edit session as a field index (-1 = not editing),
  // the three values, a commit flag and a count of quiet edit cycles.
  int m_field = -1;
  bit m_commit = 0;
  int m_val[3];
  int m_quiet = 0;

  function automatic int max_of(input int f);
    return (f == 0) ? 23 : 59;
  endfunction

  function automatic logic [20:0] model_pack();
    logic [20:0] p;
    p = {5'(m_val[0]), 6'(m_val[1]), 6'(m_val[2]),
         2'(m_field + 1), m_commit, (m_field >= 0) || m_commit};
    return p;
  endfunction

  task automatic model_reset();
    m_field = -1; m_commit = 0; m_quiet = 0;
    m_val[0] = 0; m_val[1] = 0; m_val[2] = 0;
  endtask

  task automatic model_step();
    bit anyb;
    int f, mx;
    anyb = btn_next | btn_up | btn_down | btn_cancel;
    if (m_commit) begin
      m_commit = 0;
    end else if (m_field < 0) begin
      if (btn_set) begin
        m_val[0] = (int'(cur_hours) > 23) ? 0 : int'(cur_hours);
        m_val[1] = (int'(cur_mins) > 59) ? 0 : int'(cur_mins);
        m_val[2] = (int'(cur_secs) > 59) ? 0 : int'(cur_secs);
        m_field = 0;
        m_quiet = 0;
      end
    end else begin
      f = m_field;
      mx = max_of(f);
      if (btn_cancel) m_field = -1;
      else if (btn_next) begin
        if (f == 2) begin m_field = -1; m_commit = 1; end
        else m_field = f + 1;
      end
      else if (btn_up && !btn_down) m_val[f] = (m_val[f] + 1) % (mx + 1);
      else if (btn_down && !btn_up) m_val[f] = (m_val[f] + mx) % (mx + 1);
      if (anyb) m_quiet = 0;
      else if (m_quiet == TMO - 1) m_field = -1;
      else m_quiet = m_quiet + 1;
    end
  endtask

  task automatic check(input string name, input logic [20:0] act, input logic [20:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (h,m,s,fsel,load,busy packed)", name, act, exp);
    end
  endtask

  task automatic drive(input logic s, input logic n, input logic u, input logic d, input logic c,
                       input int ch, input int cm, input int cs);
    @(negedge clk);
    btn_set = s; btn_next = n; btn_up = u; btn_down = d; btn_cancel = c;
    cur_hours = 5'(ch); cur_mins = 6'(cm); cur_secs = 6'(cs);
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic add(input logic s, input logic n, input logic u, input logic d, input logic c,
                     input int ch, input int cm, input int cs,
                     input int eh, input int em, input int es, input int ef,
                     input logic el, input logic eb);
    vec_t v;
    v.set = s; v.nxt = n; v.up = u; v.dn = d; v.cxl = c;
    v.ch = ch; v.cm = cm; v.cs = cs;
    v.eh = eh; v.em = em; v.es = es; v.ef = ef; v.el = el; v.eb = eb;
    tbl.push_back(v);
  endtask

  initial begin
    logic [20:0] exp;
    bit saw_load;
    int r;
    string nm;

    // set next up dn cxl | cur h m s | exp h m s fsel load busy
    add(1,0,0,0,0, 12,34,56, 12,34,56, 1,0,1);
    add(0,1,0,0,0, 12,34,56, 12,34,56, 2,0,1);
    add(0,1,0,0,0, 12,34,56, 12,34,56, 3,0,1);
    add(0,1,0,0,0, 12,34,56, 12,34,56, 0,1,1);
    add(0,0,0,0,0, 12,34,56, 12,34,56, 0,0,0);
    add(1,0,0,0,0, 23,59, 0, 23,59, 0, 1,0,1);
    add(0,0,1,0,0, 23,59, 0,  0,59, 0, 1,0,1);
    add(0,1,0,0,0, 23,59, 0,  0,59, 0, 2,0,1);
    add(0,0,1,0,0, 23,59, 0,  0, 0, 0, 2,0,1);
    add(0,1,0,0,0, 23,59, 0,  0, 0, 0, 3,0,1);
    add(0,0,0,1,0, 23,59, 0,  0, 0,59, 3,0,1);
    add(0,1,0,0,0, 23,59, 0,  0, 0,59, 0,1,1);
    add(0,0,0,0,0, 23,59, 0,  0, 0,59, 0,0,0);
    add(1,0,0,0,0,  5,10,20,  5,10,20, 1,0,1);
    add(0,0,1,0,0,  5,10,20,  6,10,20, 1,0,1);
    add(0,0,1,0,0,  5,10,20,  7,10,20, 1,0,1);
    add(0,0,0,0,1,  5,10,20,  7,10,20, 0,0,0);
    add(0,0,0,0,0,  5,10,20,  7,10,20, 0,0,0);
    add(1,0,0,0,0,  8,15,30,  8,15,30, 1,0,1);
    add(0,1,1,0,0,  8,15,30,  8,15,30, 2,0,1);
    add(0,0,1,1,0,  8,15,30,  8,15,30, 2,0,1);
    add(0,1,0,0,1,  8,15,30,  8,15,30, 0,0,0);
    add(0,1,1,1,1,  1, 1, 1,  8,15,30, 0,0,0);
    add(1,0,0,0,0, 31,61, 0,  0, 0, 0, 1,0,1);
    add(0,0,0,1,0, 31,61, 0, 23, 0, 0, 1,0,1);
    add(0,1,0,0,0, 31,61, 0, 23, 0, 0, 2,0,1);
    add(0,0,0,1,0, 31,61, 0, 23,59, 0, 2,0,1);
    add(0,1,0,0,0, 31,61, 0, 23,59, 0, 3,0,1);
    add(0,0,1,0,0,  2, 2, 2, 23,59, 1, 3,0,1);
    add(1,0,0,0,0,  2, 2, 2, 23,59, 1, 3,0,1);
    add(0,1,0,0,0,  2, 2, 2, 23,59, 1, 0,1,1);
    add(0,0,0,0,0,  2, 2, 2, 23,59, 1, 0,0,0);

    // Reset state
    model_reset();
    #3;
    check("reset_state", dut_pack, 21'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // Table-driven directed vectors
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].set, tbl[i].nxt, tbl[i].up, tbl[i].dn, tbl[i].cxl,
            tbl[i].ch, tbl[i].cm, tbl[i].cs);
      exp = {5'(tbl[i].eh), 6'(tbl[i].em), 6'(tbl[i].es), 2'(tbl[i].ef), tbl[i].el, tbl[i].eb};
      nm = $sformatf("vec%0d", i);
      check(nm, dut_pack, exp);
    end

    // Inactivity timeout: still editing after TMO-1 quiet cycles, IDLE after TMO
    drive(1,0,0,0,0, 12,0,0);
    saw_load = 1'b0;
    for (int i = 1; i <= TMO; i++) begin
      drive(0,0,0,0,0, 12,0,0);
      if (load) saw_load = 1'b1;
      if (i == TMO - 1) check("timeout_hold", dut_pack, {5'd12, 6'd0, 6'd0, 2'd1, 1'b0, 1'b1});
      if (i == TMO)     check("timeout_abort", dut_pack, {5'd12, 6'd0, 6'd0, 2'd0, 1'b0, 1'b0});
    end
    check("timeout_no_load", {20'd0, saw_load}, 21'd0);

    // Asynchronous reset during COMMIT
    drive(1,0,0,0,0, 9,8,7);
    drive(0,1,0,0,0, 9,8,7);
    drive(0,1,0,0,0, 9,8,7);
    drive(0,1,0,0,0, 9,8,7);
    check("commit_before_rst", dut_pack, {5'd9, 6'd8, 6'd7, 2'd0, 1'b1, 1'b1});
    #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("rst_in_commit", dut_pack, 21'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1,0,0,0,0, 1,2,3);
    check("after_rst_set", dut_pack, {5'd1, 6'd2, 6'd3, 2'd1, 1'b0, 1'b1});

    // Randomized stimulus against the reference model
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 3);
      if (r == 0) begin
        drive(($urandom_range(0, 5) == 0), ($urandom_range(0, 3) == 0),
              ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0),
              ($urandom_range(0, 11) == 0),
              $urandom_range(0, 31), $urandom_range(0, 63), $urandom_range(0, 63));
      end else begin
        drive(0,0,0,0,0, $urandom_range(0, 31), $urandom_range(0, 63), $urandom_range(0, 63));
      end
      nm = $sformatf("rand%0d", i);
      check(nm, dut_pack, model_pack());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/set_ctrl24.md
SET_CTRL24 -- requirements
Module: set_ctrl24

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 1000, idle cycles in edit before auto-abort.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 btn_set  input  1  one-cycle pulse; enters set mode from IDLE.
REQ-005 btn_next  input  1  one-cycle pulse; advances to next field / commits.
REQ-006 btn_up  input  1  one-cycle pulse; increments selected field.
REQ-007 btn_down  input  1  one-cycle pulse; decrements selected field.
REQ-008 btn_cancel  input  1  one-cycle pulse; abandons edit without load.
REQ-009 cur_hours/cur_mins/cur_secs  input  5/6/6  live time, captured on entry.
REQ-010 hours_o/mins_o/secs_o  output  5/6/6  edited values, registered; feed time setter.
REQ-011 field_sel  output  2  0=none, 1=hours, 2=mins, 3=secs; registered.
REQ-012 load  output  1  one-cycle commit strobe; hours_o/mins_o/secs_o valid that cycle.
REQ-013 busy  output  1  high in any state except IDLE.

Function
REQ-014 States SHALL be IDLE, EDIT_H, EDIT_M, EDIT_S, COMMIT.
REQ-015 IDLE + btn_set -> EDIT_H next cycle; cur_* SHALL be captured into hours_o/mins_o/secs_o same edge.
REQ-016 Captured value out of range (hours>23, mins/secs>59) SHALL be replaced by 0.
REQ-017 btn_next: EDIT_H->EDIT_M->EDIT_S->COMMIT; COMMIT->IDLE unconditionally after one cycle.
REQ-018 load SHALL be 1 exactly during COMMIT, 0 otherwise.
REQ-019 btn_up in EDIT_x: field +1, wrapping 23->0 (hours), 59->0 (mins/secs).
REQ-020 btn_down in EDIT_x: field -1, wrapping 0->23 (hours), 0->59 (mins/secs).
REQ-021 Unselected fields SHALL hold value.
REQ-022 Priority per cycle: btn_cancel > btn_next > (btn_up/btn_down); lower-priority inputs ignored that cycle.
REQ-023 btn_up and btn_down together (no higher-priority input) SHALL leave field unchanged.
REQ-024 btn_cancel in any EDIT_x -> IDLE, no load; outputs retain last edited values.
REQ-025 Inactivity counter SHALL reset on any button pulse and on entry to EDIT_H; reaching TIMEOUT_CYCLES-1 in EDIT_x -> IDLE, no load.
REQ-026 All buttons other than btn_set SHALL be ignored in IDLE; btn_set ignored outside IDLE.
REQ-027 field_sel SHALL equal 1/2/3 in EDIT_H/M/S, 0 in IDLE and COMMIT; busy=1 in COMMIT.
REQ-028 Inputs cur_* SHALL not affect outputs except at capture.

Reset
REQ-029 rst_n low SHALL force, asynchronously: state IDLE, hours_o=mins_o=secs_o=0, field_sel=0, load=0, busy=0, timeout counter 0.
REQ-030 Reset asserted mid-edit or during COMMIT SHALL abort without load; release returns to IDLE behaviour on next edge.

Structure
REQ-031 Shared package time_pkg SHALL hold state enum, MAX_HOUR=23, MAX_MINSEC=59, field_sel encodings.
REQ-032 One sub-module mod_adj (modulo up/down adjuster, parameter MAX) SHALL be instanced three times for the fields.
REQ-033 Timeout counter width SHALL be $clog2(TIMEOUT_CYCLES); FSM and counter in set_ctrl24.

Verification
REQ-034 cur=12:34:56, btn_set, next, next, next -> load pulse one cycle with 12:34:56, busy low after.
REQ-035 cur=23:59:00, btn_set, up (hours), next, up (mins), next, down (secs), next -> load 00:00:59.
REQ-036 cur=05:10:20, btn_set, up x2, cancel -> no load, state IDLE, hours_o=7.
REQ-037 btn_set then no buttons for TIMEOUT_CYCLES cycles -> IDLE, load never asserted; next+up same cycle in EDIT_H -> EDIT_M, hours unchanged.
REQ-038 cur=31:61:00 captured -> outputs 00:00:00; rst_n low during COMMIT -> load drops immediately, all outputs 0.
